// File: rtl/flow_led_ctrl_if.sv
// Pin bundle for the flow LED controller: raw key in, LED pattern, mode and step strobe out.
interface flow_led_ctrl_if;
  logic       KEY_n;
  logic [3:0] LED;
  logic [1:0] MODE;
  logic       STEP_TICK;

  modport master (output KEY_n, input LED, MODE, STEP_TICK);
  modport slave  (input KEY_n, output LED, MODE, STEP_TICK);
endinterface

// File: rtl/flow_led_ctrl.sv
// Flowing-LED controller: free-running step timer, debounced mode key, four display modes
// (rotate left, rotate right, ping-pong bounce, hold).
module flow_led_ctrl #(
  parameter logic [22:0] T_STEP = 23'd5_000_000,
  parameter logic [19:0] T_DEB  = 20'd1_000_000
) (
  input  logic            CLK,
  input  logic            RSTn,
  flow_led_ctrl_if.slave  io
);

  localparam int unsigned STEP_W = 23;
  localparam int unsigned DEB_W  = 20;
  localparam logic [STEP_W-1:0] STEP_LAST = T_STEP - STEP_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = T_DEB - DEB_W'(1);

  typedef enum logic [1:0] {
    LEFT   = 2'b00,
    RIGHT  = 2'b01,
    BOUNCE = 2'b10,
    HOLD   = 2'b11
  } mode_e;

  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              step_tick_q;
  logic [1:0]        sync_q;
  logic              key_stable_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic              key_sync;
  logic              deb_done_c;
  logic              key_press_c;
  mode_e             state_q, state_d;
  logic [3:0]        pat_q, pat_d;
  logic              dir_up_q, dir_up_d;

  // Step timer; the strobe is registered so it is high while the counter sits at T_STEP-1
  assign step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + STEP_W'(1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      step_cnt_q  <= '0;
      step_tick_q <= 1'b0;
    end else begin
      step_cnt_q  <= step_cnt_d;
      step_tick_q <= (step_cnt_d == STEP_LAST);
    end
  end

  // Two-flop synchroniser followed by a consecutive-difference debounce counter
  assign key_sync    = sync_q[1];
  assign deb_done_c  = (key_sync != key_stable_q) && (deb_cnt_q == DEB_LAST);
  assign key_press_c = deb_done_c && key_stable_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q       <= 2'b11;
      key_stable_q <= 1'b1;
      deb_cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], io.KEY_n};
      if (key_sync == key_stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_done_c) begin
        key_stable_q <= key_sync;
        deb_cnt_q    <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Mode FSM
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= LEFT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (key_press_c) begin
      case (state_q)
        LEFT:    state_d = RIGHT;
        RIGHT:   state_d = BOUNCE;
        BOUNCE:  state_d = HOLD;
        default: state_d = LEFT;
      endcase
    end
  end

  // Pattern step uses the pre-edge mode; entering BOUNCE always starts heading up
  always_comb begin
    pat_d    = pat_q;
    dir_up_d = dir_up_q;
    if (!$onehot(pat_q)) begin
      pat_d = 4'b0001;
    end else if (step_tick_q) begin
      case (state_q)
        LEFT:  pat_d = {pat_q[2:0], pat_q[3]};
        RIGHT: pat_d = {pat_q[0], pat_q[3:1]};
        BOUNCE: begin
          if (dir_up_q) begin
            if (pat_q[3]) begin
              pat_d    = 4'b0100;
              dir_up_d = 1'b0;
            end else begin
              pat_d = {pat_q[2:0], 1'b0};
            end
          end else begin
            if (pat_q[0]) begin
              pat_d    = 4'b0010;
              dir_up_d = 1'b1;
            end else begin
              pat_d = {1'b0, pat_q[3:1]};
            end
          end
        end
        default: pat_d = pat_q;
      endcase
    end
    if (key_press_c && (state_q == RIGHT)) dir_up_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pat_q    <= 4'b0001;
      dir_up_q <= 1'b1;
    end else begin
      pat_q    <= pat_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign io.LED       = pat_q;
  assign io.MODE      = state_q;
  assign io.STEP_TICK = step_tick_q;

endmodule
